// File: rtl/bus_node_fifo.sv
// bus_node_fifo: per-slot bus node with a TX FIFO (host -> arbiter) and an
// address-filtered RX FIFO (arbiter -> host), plus drop/overflow statistics.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   tx_push/tx_data  host write into TX FIFO; tx_full reports TX full
//   pndng/D_pop/pop  TX FIFO non-empty, show-ahead head word, arbiter consume
//   push/D_push      arbiter delivers a packet to the RX filter
//   rx_pop/rx_data   host consume, show-ahead RX head word
//   rx_valid         RX FIFO non-empty
//   rx_count         RX occupancy
//   drop_cnt         packets rejected by address filter (saturating)
//   ovf_cnt          accepted packets lost to RX full (saturating)
//   err_flags        sticky [0] pop on empty TX, [1] tx_push dropped on full TX
module bus_node_fifo #(
   parameter int unsigned PCKG_SZ   = 16,
   parameter int unsigned DEPTH     = 8,
   parameter logic [7:0]  ID        = 8'h00,
   parameter logic [7:0]  BROADCAST = 8'hFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tx_push,
   input  logic [PCKG_SZ-1:0]           tx_data,
   output logic                         tx_full,
   output logic                         pndng,
   output logic [PCKG_SZ-1:0]           D_pop,
   input  logic                         pop,
   input  logic                         push,
   input  logic [PCKG_SZ-1:0]           D_push,
   input  logic                         rx_pop,
   output logic [PCKG_SZ-1:0]           rx_data,
   output logic                         rx_valid,
   output logic [$clog2(DEPTH+1)-1:0]   rx_count,
   output logic [15:0]                  drop_cnt,
   output logic [15:0]                  ovf_cnt,
   output logic [1:0]                   err_flags
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   // TX FIFO state
   logic [PCKG_SZ-1:0] tx_mem_q [DEPTH];
   logic [PCKG_SZ-1:0] tx_mem_d [DEPTH];
   logic [AW-1:0]      tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [CW-1:0]      tx_cnt_q, tx_cnt_d;

   // RX FIFO state
   logic [PCKG_SZ-1:0] rx_mem_q [DEPTH];
   logic [PCKG_SZ-1:0] rx_mem_d [DEPTH];
   logic [AW-1:0]      rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0]      rx_cnt_q, rx_cnt_d;

   // Statistics and sticky errors
   logic [15:0]        drop_cnt_q, drop_cnt_d;
   logic [15:0]        ovf_cnt_q, ovf_cnt_d;
   logic [1:0]         err_q, err_d;

   // Per-cycle strobes
   logic               tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
   logic               tx_rd_en, tx_wr_en, rx_rd_en, rx_wr_en;
   logic               addr_hit;
   logic [7:0]         dest;

   assign tx_full_s  = (tx_cnt_q == CW'(DEPTH));
   assign tx_empty_s = (tx_cnt_q == '0);
   assign rx_full_s  = (rx_cnt_q == CW'(DEPTH));
   assign rx_empty_s = (rx_cnt_q == '0);

   assign dest     = D_push[PCKG_SZ-1 -: 8];
   assign addr_hit = (dest == ID) || (dest == BROADCAST);

   // A read frees a slot in the same cycle, so a full FIFO still accepts a
   // write when it is being popped; an empty FIFO never falls through.
   assign tx_rd_en = pop && !tx_empty_s;
   assign tx_wr_en = tx_push && (!tx_full_s || tx_rd_en);
   assign rx_rd_en = rx_pop && !rx_empty_s;
   assign rx_wr_en = push && addr_hit && (!rx_full_s || rx_rd_en);

   // Next-state logic for both FIFOs, counters and flags
   always_comb begin
      tx_mem_d   = tx_mem_q;
      tx_wr_d    = tx_wr_q;
      tx_rd_d    = tx_rd_q;
      tx_cnt_d   = tx_cnt_q;
      rx_mem_d   = rx_mem_q;
      rx_wr_d    = rx_wr_q;
      rx_rd_d    = rx_rd_q;
      rx_cnt_d   = rx_cnt_q;
      drop_cnt_d = drop_cnt_q;
      ovf_cnt_d  = ovf_cnt_q;
      err_d      = err_q;

      if (tx_wr_en) begin
         tx_mem_d[tx_wr_q] = tx_data;
         tx_wr_d           = AW'(tx_wr_q + 1'b1);
      end
      if (tx_rd_en) begin
         tx_rd_d = AW'(tx_rd_q + 1'b1);
      end
      case ({tx_wr_en, tx_rd_en})
         2'b10:   tx_cnt_d = CW'(tx_cnt_q + 1'b1);
         2'b01:   tx_cnt_d = CW'(tx_cnt_q - 1'b1);
         default: tx_cnt_d = tx_cnt_q;
      endcase

      if (pop && tx_empty_s) begin
         err_d[0] = 1'b1;
      end
      if (tx_push && !tx_wr_en) begin
         err_d[1] = 1'b1;
      end

      if (rx_wr_en) begin
         rx_mem_d[rx_wr_q] = D_push;
         rx_wr_d           = AW'(rx_wr_q + 1'b1);
      end
      if (rx_rd_en) begin
         rx_rd_d = AW'(rx_rd_q + 1'b1);
      end
      case ({rx_wr_en, rx_rd_en})
         2'b10:   rx_cnt_d = CW'(rx_cnt_q + 1'b1);
         2'b01:   rx_cnt_d = CW'(rx_cnt_q - 1'b1);
         default: rx_cnt_d = rx_cnt_q;
      endcase

      if (push && !addr_hit && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = 16'(drop_cnt_q + 16'd1);
      end
      if (push && addr_hit && !rx_wr_en && (ovf_cnt_q != 16'hFFFF)) begin
         ovf_cnt_d = 16'(ovf_cnt_q + 16'd1);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            tx_mem_q[i] <= '0;
            rx_mem_q[i] <= '0;
         end
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         tx_cnt_q   <= '0;
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         rx_cnt_q   <= '0;
         drop_cnt_q <= '0;
         ovf_cnt_q  <= '0;
         err_q      <= '0;
      end else begin
         tx_mem_q   <= tx_mem_d;
         tx_wr_q    <= tx_wr_d;
         tx_rd_q    <= tx_rd_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_mem_q   <= rx_mem_d;
         rx_wr_q    <= rx_wr_d;
         rx_rd_q    <= rx_rd_d;
         rx_cnt_q   <= rx_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         ovf_cnt_q  <= ovf_cnt_d;
         err_q      <= err_d;
      end
   end

   // Outputs depend only on registered state; heads read as zero when empty
   assign tx_full   = tx_full_s;
   assign pndng     = !tx_empty_s;
   assign D_pop     = tx_empty_s ? '0 : tx_mem_q[tx_rd_q];
   assign rx_valid  = !rx_empty_s;
   assign rx_data   = rx_empty_s ? '0 : rx_mem_q[rx_rd_q];
   assign rx_count  = rx_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign ovf_cnt   = ovf_cnt_q;
   assign err_flags = err_q;

endmodule

// File: tb/tb_bus_node_fifo.sv
// tb_bus_node_fifo: directed and randomized traffic against a queue-based
// reference model of the bus node (ID=3, DEPTH=8, PCKG_SZ=16).
module tb_bus_node_fifo;

   localparam int unsigned PW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;
   localparam logic [7:0]  MY_ID = 8'h03;
   localparam logic [7:0]  BC    = 8'hFF;

   logic          clk = 1'b0;
   logic          reset;
   logic          tx_push, pop, push, rx_pop;
   logic [PW-1:0] tx_data, D_push;
   logic          tx_full, pndng, rx_valid;
   logic [PW-1:0] D_pop, rx_data;
   logic [CW-1:0] rx_count;
   logic [15:0]   drop_cnt, ovf_cnt;
   logic [1:0]    err_flags;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [PW-1:0] txq[$];
   logic [PW-1:0] rxq[$];
   int unsigned   m_drop, m_ovf;
   logic [1:0]    m_err;

   bus_node_fifo #(.PCKG_SZ(PW), .DEPTH(DEPTH), .ID(MY_ID), .BROADCAST(BC)) dut (
      .clk(clk), .reset(reset),
      .tx_push(tx_push), .tx_data(tx_data), .tx_full(tx_full),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rx_pop(rx_pop), .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
      .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      txq.delete();
      rxq.delete();
      m_drop = 0;
      m_ovf  = 0;
      m_err  = 2'b00;
   endtask

   // One clock of behaviour from the rules, applied to pre-edge model state
   task automatic model_step(input logic tp, input logic [PW-1:0] td, input logic p,
                             input logic ps, input logic [PW-1:0] dp, input logic rp);
      bit pop_ok, push_ok, hit, rpop_ok;
      pop_ok  = p && (txq.size() > 0);
      push_ok = tp && ((txq.size() < DEPTH) || pop_ok);
      if (p && txq.size() == 0) m_err[0] = 1'b1;
      if (tp && !push_ok)       m_err[1] = 1'b1;
      if (pop_ok)  void'(txq.pop_front());
      if (push_ok) txq.push_back(td);

      hit     = (dp[15:8] == MY_ID) || (dp[15:8] == BC);
      rpop_ok = rp && (rxq.size() > 0);
      if (ps && !hit && m_drop < 65535) m_drop++;
      if (rpop_ok) void'(rxq.pop_front());
      if (ps && hit) begin
         if (rxq.size() < DEPTH) rxq.push_back(dp);
         else if (m_ovf < 65535) m_ovf++;
      end
   endtask

   task automatic check_all(input string tag);
      logic [PW-1:0] exp_dpop, exp_rx;
      exp_dpop = (txq.size() > 0) ? txq[0] : '0;
      exp_rx   = (rxq.size() > 0) ? rxq[0] : '0;
      check({tag, ".pndng"},    32'(pndng),     32'(txq.size() > 0));
      check({tag, ".tx_full"},  32'(tx_full),   32'(txq.size() == DEPTH));
      check({tag, ".D_pop"},    32'(D_pop),     32'(exp_dpop));
      check({tag, ".rx_valid"}, 32'(rx_valid),  32'(rxq.size() > 0));
      check({tag, ".rx_count"}, 32'(rx_count),  32'(rxq.size()));
      check({tag, ".rx_data"},  32'(rx_data),   32'(exp_rx));
      check({tag, ".drop_cnt"}, 32'(drop_cnt),  m_drop);
      check({tag, ".ovf_cnt"},  32'(ovf_cnt),   m_ovf);
      check({tag, ".err"},      32'(err_flags), 32'(m_err));
   endtask

   task automatic step(input string tag, input logic tp, input logic [PW-1:0] td,
                       input logic p, input logic ps, input logic [PW-1:0] dp,
                       input logic rp, input bit do_check = 1'b1);
      @(negedge clk);
      tx_push = tp; tx_data = td; pop = p; push = ps; D_push = dp; rx_pop = rp;
      @(posedge clk);
      model_step(tp, td, p, ps, dp, rp);
      #1;
      if (do_check) check_all(tag);
   endtask

   task automatic idle_inputs();
      tx_push = 0; tx_data = '0; pop = 0; push = 0; D_push = '0; rx_pop = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      logic [PW-1:0] d;
      idle_inputs();
      reset = 1'b0;
      model_clear();
      #12;
      check_all("por");
      @(negedge clk);
      reset = 1'b1;

      // 1: async reset in the middle of a burst
      for (int i = 0; i < 5; i++)
         step("rst_burst", 1'b1, 16'h1100 + 16'(i), 1'b0, 1'b1, {MY_ID, 8'(i)}, 1'b0);
      step("rst_burst", 1'b0, '0, 1'b0, 1'b1, 16'h5500, 1'b0);
      @(negedge clk);
      tx_push = 1; tx_data = 16'hBEEF; push = 1; D_push = 16'h03EE;
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      check_all("rst_async");
      @(negedge clk);
      idle_inputs();
      #1;
      check_all("rst_held");
      reset = 1'b1;
      step("rst_after", 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

      // 2: TX ordering, full, dropped push
      do_reset();
      for (int i = 1; i <= 9; i++)
         step("tx_fill", 1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
      check("tx_full_const", 32'(tx_full), 32'd1);
      check("tx_err1_const", 32'(err_flags[1]), 32'd1);
      for (int i = 1; i <= 8; i++) begin
         check("tx_order", 32'(D_pop), 32'h0A00 + 32'(i));
         step("tx_drain", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      end
      check("tx_empty_const", 32'(pndng), 32'd0);

      // 3: address filter
      do_reset();
      step("flt", 1'b0, '0, 1'b0, 1'b1, 16'h03AA, 1'b0);
      step("flt", 1'b0, '0, 1'b0, 1'b1, 16'hFF55, 1'b0);
      step("flt", 1'b0, '0, 1'b0, 1'b1, 16'h07CC, 1'b0);
      check("flt_count_const", 32'(rx_count), 32'd2);
      check("flt_drop_const", 32'(drop_cnt), 32'd1);
      check("flt_head0_const", 32'(rx_data), 32'h03AA);
      step("flt_pop", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      check("flt_head1_const", 32'(rx_data), 32'hFF55);

      // 4: RX overflow, then push+pop while full
      do_reset();
      for (int i = 0; i < 10; i++)
         step("ovf", 1'b0, '0, 1'b0, 1'b1, 16'h0300 + 16'(i), 1'b0);
      check("ovf_count_const", 32'(rx_count), 32'd8);
      check("ovf_cnt_const", 32'(ovf_cnt), 32'd2);
      for (int i = 0; i < 3; i++)
         step("ovf_pp", 1'b0, '0, 1'b0, 1'b1, 16'h03F0 + 16'(i), 1'b1);
      check("ovf_pp_count_const", 32'(rx_count), 32'd8);
      check("ovf_pp_cnt_const", 32'(ovf_cnt), 32'd2);
      step("rx_empty_pop", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);

      // 5: wrap with simultaneous push+pop, TX full push+pop, pop on empty
      do_reset();
      for (int i = 0; i < 4; i++)
         step("wrap_fill", 1'b1, 16'hC000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
      for (int i = 4; i < 24; i++)
         step("wrap_pp", 1'b1, 16'hC000 + 16'(i), 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("wrap_order", 32'(D_pop), 32'hC014 + 32'(i));
         step("wrap_drain", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      end
      step("pop_empty", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      check("pop_empty_err0_const", 32'(err_flags[0]), 32'd1);
      step("empty_pp", 1'b1, 16'h7777, 1'b1, 1'b0, '0, 1'b0);
      check("empty_pp_const", 32'(D_pop), 32'h7777);
      do_reset();
      for (int i = 0; i < 8; i++)
         step("full_fill", 1'b1, 16'hD000 + 16'(i), 1'b0, 1'b0, '0, 1'b0);
      step("full_pp", 1'b1, 16'hD008, 1'b1, 1'b0, '0, 1'b0);
      check("full_pp_err1_const", 32'(err_flags[1]), 32'd0);

      // Randomized mixed traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         case ($urandom_range(0, 3))
            0:       d = {MY_ID, 8'($urandom)};
            1:       d = {BC, 8'($urandom)};
            default: d = 16'($urandom);
         endcase
         step("rand", 1'($urandom_range(0, 99) < 55), 16'($urandom),
              1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 60), d,
              1'($urandom_range(0, 99) < 35));
      end

      // 6: drop counter saturation
      do_reset();
      for (int i = 0; i < 65537; i++)
         step("sat", 1'b0, '0, 1'b0, 1'b1, 16'h5500 + 16'(i & 255), 1'b0, 1'b0);
      check_all("sat");
      check("sat_const", 32'(drop_cnt), 32'h0000_FFFF);
      step("sat_more", 1'b0, '0, 1'b0, 1'b1, 16'h5501, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
